// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates from dispatch, collects CDB writebacks and
// retires one ready head entry per cycle, with a commit handshake for stores.
package reorder_buffer_pkg;
    typedef logic [4:0]  Register;
    typedef logic [31:0] MemoryWord;

    typedef struct packed {
        logic regwr;
        logic memwr;
        logic ecall;
        logic unsupported;
    } ctrl_t;

    typedef struct packed {
        Register   rd;
        ctrl_t     ctrl_bits;
        MemoryWord value;
        logic      ready;
    } rob_entry;

    typedef struct packed {
        int        tag;
        MemoryWord value;
    } cdb;

    typedef struct packed {
        Register   regstr;
        MemoryWord value;
    } Victim;
endpackage

module reorder_buffer
    import reorder_buffer_pkg::*;
#(
    parameter int ROB_SIZE = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    rob_increment,
    input  rob_entry                re,
    input  cdb                      cdb1,
    input  cdb                      cdb2,
    input  logic                    store_commit_ack,
    output rob_entry [ROB_SIZE-1:0] rob,
    output int                      rob_tail,
    output int                      rob_head,
    output int                      rob_count,
    output Victim                   victim,
    output logic                    rf_we,
    output Register                 rf_rd,
    output MemoryWord               rf_value,
    output int                      commit_tag,
    output logic                    store_commit_valid,
    output int                      store_commit_tag,
    output logic                    halt
);
    localparam int IdxW = (ROB_SIZE > 1) ? $clog2(ROB_SIZE) : 1;

    typedef enum logic {StCommit, StStoreWait} state_t;

    state_t                  state_q, state_d;
    rob_entry [ROB_SIZE-1:0] rob_q, rob_d;
    int                      tail_q, tail_d, head_q, head_d, count_q, count_d;
    int                      commit_tag_q, commit_tag_d, sc_tag_q, sc_tag_d;
    Victim                   victim_q, victim_d;
    logic                    rf_we_q, rf_we_d, sc_valid_q, sc_valid_d, halt_q, halt_d;
    Register                 rf_rd_q, rf_rd_d;
    MemoryWord               rf_value_q, rf_value_d;
    logic                    retire, reg_write, offer, alloc;
    logic [IdxW-1:0]         head_idx, tail_idx;
    rob_entry                head_entry;
    logic [ROB_SIZE-1:0]     live;

    function automatic int next_tag(input int t);
        return (t >= ROB_SIZE) ? 1 : t + 1;
    endfunction

    assign head_idx   = IdxW'(head_q - 1);
    assign tail_idx   = IdxW'(tail_q - 1);
    assign head_entry = rob_q[head_idx];

    // A slot is live when its distance from the head is below the occupancy.
    always_comb begin
        for (int i = 0; i < ROB_SIZE; i++) begin
            live[i] = ((i + 1 - head_q + ROB_SIZE) % ROB_SIZE) < count_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        rob_d     = rob_q;
        head_d    = head_q;
        tail_d    = tail_q;
        halt_d    = halt_q;
        retire    = 1'b0;
        reg_write = 1'b0;
        offer     = 1'b0;

        unique case (state_q)
            StCommit: begin
                if (count_q > 0 && head_entry.ready && !halt_q) begin
                    if (head_entry.ctrl_bits.memwr) begin
                        state_d = StStoreWait;
                        offer   = 1'b1;
                    end else begin
                        retire = 1'b1;
                        if (head_entry.ctrl_bits.ecall) begin
                            halt_d = 1'b1;
                        end else if (!head_entry.ctrl_bits.unsupported) begin
                            reg_write = head_entry.ctrl_bits.regwr && (head_entry.rd != '0);
                        end
                    end
                end
            end
            StStoreWait: begin
                if (store_commit_ack) begin
                    retire  = 1'b1;
                    state_d = StCommit;
                end else begin
                    offer = 1'b1;
                end
            end
            default: state_d = StCommit;
        endcase

        // cdb1 is applied last so it wins on a shared tag.
        for (int i = 0; i < ROB_SIZE; i++) begin
            if (live[i] && cdb2.tag == i + 1) begin
                rob_d[i].value = cdb2.value;
                rob_d[i].ready = 1'b1;
            end
            if (live[i] && cdb1.tag == i + 1) begin
                rob_d[i].value = cdb1.value;
                rob_d[i].ready = 1'b1;
            end
        end

        if (retire) begin
            rob_d[head_idx] = '0;
            head_d          = next_tag(head_q);
        end

        // A full buffer still accepts an allocation into the slot freed this cycle.
        alloc = rob_increment && ((count_q < ROB_SIZE) || retire);
        if (alloc) begin
            rob_d[tail_idx] = re;
            tail_d          = next_tag(tail_q);
        end
        count_d = count_q + (alloc ? 1 : 0) - (retire ? 1 : 0);

        commit_tag_d = retire ? head_q : 0;
        rf_we_d      = reg_write;
        rf_rd_d      = reg_write ? head_entry.rd : '0;
        rf_value_d   = reg_write ? head_entry.value : '0;
        victim_d     = '0;
        if (reg_write) begin
            victim_d.regstr = head_entry.rd;
            victim_d.value  = head_entry.value;
        end
        sc_valid_d = offer;
        sc_tag_d   = offer ? head_q : 0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StCommit;
            rob_q        <= '0;
            tail_q       <= 1;
            head_q       <= 1;
            count_q      <= 0;
            commit_tag_q <= 0;
            sc_tag_q     <= 0;
            victim_q     <= '0;
            rf_we_q      <= 1'b0;
            rf_rd_q      <= '0;
            rf_value_q   <= '0;
            sc_valid_q   <= 1'b0;
            halt_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rob_q        <= rob_d;
            tail_q       <= tail_d;
            head_q       <= head_d;
            count_q      <= count_d;
            commit_tag_q <= commit_tag_d;
            sc_tag_q     <= sc_tag_d;
            victim_q     <= victim_d;
            rf_we_q      <= rf_we_d;
            rf_rd_q      <= rf_rd_d;
            rf_value_q   <= rf_value_d;
            sc_valid_q   <= sc_valid_d;
            halt_q       <= halt_d;
        end
    end

    assign rob                = rob_q;
    assign rob_tail           = tail_q;
    assign rob_head           = head_q;
    assign rob_count          = count_q;
    assign victim             = victim_q;
    assign rf_we              = rf_we_q;
    assign rf_rd              = rf_rd_q;
    assign rf_value           = rf_value_q;
    assign commit_tag         = commit_tag_q;
    assign store_commit_valid = sc_valid_q;
    assign store_commit_tag   = sc_tag_q;
    assign halt               = halt_q;
endmodule
